// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage 8-bit pipeline: tracks EX/MEM/WB
// destination tags, drives operand-forward selects, stalls on hazards, flushes on branches.
module hazard_ctrl #(
   parameter int unsigned RA_W      = 2,
   parameter int unsigned RF_BYPASS = 0,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [RA_W-1:0]  id_ra,
   input  logic [RA_W-1:0]  id_rb,
   input  logic             id_use_a,
   input  logic             id_use_b,
   input  logic             id_wr_en,
   input  logic             id_is_load,
   input  logic             br_taken,
   output logic [1:0]       a_dh_sel,
   output logic [1:0]       b_dh_sel,
   output logic             pc_en,
   output logic             if_en,
   output logic             if_flush,
   output logic             id_bubble,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef struct packed {
      logic            valid;
      logic [RA_W-1:0] dest;
      logic            is_load;
   } tag_t;

   localparam logic [CNT_W-1:0] CntMax  = '1;
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
   localparam logic             RfStall = (RF_BYPASS == 0);

   tag_t             t1_q, t2_q, t3_q, id_tag;
   logic             a_m1, a_m2, a_m3, b_m1, b_m2, b_m3;
   logic             ld_hz, rf_hz, stall;
   logic [1:0]       a_sel_d, a_sel_q, b_sel_d, b_sel_q;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   assign id_tag = {id_valid & id_wr_en, id_ra, id_is_load};

   always_comb begin
      a_m1 = id_use_a & t1_q.valid & (t1_q.dest == id_ra);
      a_m2 = id_use_a & t2_q.valid & (t2_q.dest == id_ra);
      a_m3 = id_use_a & t3_q.valid & (t3_q.dest == id_ra);
      b_m1 = id_use_b & t1_q.valid & (t1_q.dest == id_rb);
      b_m2 = id_use_b & t2_q.valid & (t2_q.dest == id_rb);
      b_m3 = id_use_b & t3_q.valid & (t3_q.dest == id_rb);
   end

   // A WB-only match needs a stall unless the register file writes through.
   assign ld_hz = (a_m1 | b_m1) & t1_q.is_load;
   assign rf_hz = RfStall & ((a_m3 & ~a_m1 & ~a_m2) | (b_m3 & ~b_m1 & ~b_m2));
   assign stall = id_valid & (ld_hz | rf_hz) & ~br_taken;

   assign pc_en     = ~stall;
   assign if_en     = ~stall;
   assign if_flush  = br_taken;
   assign id_bubble = stall | br_taken;

   always_comb begin
      a_sel_d = 2'b00;
      b_sel_d = 2'b00;
      if (!id_bubble) begin
         if (a_m1 && !t1_q.is_load) a_sel_d = 2'b10;
         else if (a_m2)             a_sel_d = 2'b01;
         if (b_m1 && !t1_q.is_load) b_sel_d = 2'b10;
         else if (b_m2)             b_sel_d = 2'b01;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         t1_q        <= '0;
         t2_q        <= '0;
         t3_q        <= '0;
         a_sel_q     <= 2'b00;
         b_sel_q     <= 2'b00;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         t1_q    <= id_bubble ? tag_t'('0) : id_tag;
         t2_q    <= t1_q;
         t3_q    <= t2_q;
         a_sel_q <= a_sel_d;
         b_sel_q <= b_sel_d;
         if (stall && stall_cnt_q != CntMax)    stall_cnt_q <= stall_cnt_q + CntOne;
         if (br_taken && flush_cnt_q != CntMax) flush_cnt_q <= flush_cnt_q + CntOne;
      end
   end

   assign a_dh_sel  = a_sel_q;
   assign b_dh_sel  = b_sel_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
